// File: rtl/aes128_sbox_scheduler.sv
// Time-shares NUM_SBOX Rijndael S-boxes between a 128-bit SubBytes job and a
// 32-bit SubWord job, round-robin arbitrated, one job in flight at a time.

module aes128_rijndael_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x14, w_x15;
  logic [7:0] w_x30, w_x60, w_x120, w_x240, w_x252, w_inv;

  // Multiplicative inverse as x^254 (maps 0 to 0 without a special case)
  assign w_x2   = gf_mul(i_byte, i_byte);
  assign w_x3   = gf_mul(w_x2, i_byte);
  assign w_x6   = gf_mul(w_x3, w_x3);
  assign w_x12  = gf_mul(w_x6, w_x6);
  assign w_x14  = gf_mul(w_x12, w_x2);
  assign w_x15  = gf_mul(w_x14, i_byte);
  assign w_x30  = gf_mul(w_x15, w_x15);
  assign w_x60  = gf_mul(w_x30, w_x30);
  assign w_x120 = gf_mul(w_x60, w_x60);
  assign w_x240 = gf_mul(w_x120, w_x120);
  assign w_x252 = gf_mul(w_x240, w_x12);
  assign w_inv  = gf_mul(w_x252, w_x2);

  assign o_byte = w_inv
                ^ {w_inv[6:0], w_inv[7]}
                ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]}
                ^ {w_inv[3:0], w_inv[7:4]}
                ^ 8'h63;

endmodule

module aes128_sbox_scheduler #(
  parameter int NUM_SBOX = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         state_req_i,
  input  logic [127:0] state_data_i,
  output logic         state_done_o,
  output logic [127:0] state_data_o,
  input  logic         key_req_i,
  input  logic [31:0]  key_data_i,
  output logic         key_done_o,
  output logic [31:0]  key_data_o,
  output logic         busy_o
);

  localparam int SB = 8 * NUM_SBOX;
  localparam int CW = (16 / NUM_SBOX > 2) ? $clog2(16 / NUM_SBOX) : 1;
  localparam logic [CW-1:0] ST_LAST  = CW'(16 / NUM_SBOX - 1);
  localparam logic [CW-1:0] KEY_LAST = CW'(4 / NUM_SBOX - 1);

  generate
    if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_param
      $error("aes128_sbox_scheduler: NUM_SBOX must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_gnt_key;
  logic            r_rr_ptr;
  logic [CW-1:0]   r_cnt;
  logic [127:0]    r_work;
  logic [127-SB:0] r_res;
  logic [127:0]    r_state_data;
  logic [31:0]     r_key_data;

  logic            w_any_req;
  logic            w_grant_key;
  logic            w_last;
  logic [SB-1:0]   w_sb_out;
  logic [127:0]    w_res_next;

  assign w_any_req   = state_req_i | key_req_i;
  assign w_grant_key = key_req_i & (~state_req_i | r_rr_ptr);
  assign w_last      = (r_cnt == (r_gnt_key ? KEY_LAST : ST_LAST));

  // Work reg shifts right each beat; results enter from the top so byte order
  // lands correctly after the last beat (key result ends up in the top word).
  assign w_res_next  = {w_sb_out, r_res};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SBOX; gi++) begin : g_sbox
      aes128_rijndael_sbox u_sbox (
        .i_byte (r_work[8*gi +: 8]),
        .o_byte (w_sb_out[8*gi +: 8])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o       = 1'b0;
    state_done_o = 1'b0;
    key_done_o   = 1'b0;
    if (r_state != S_IDLE) busy_o = 1'b1;
    if (r_state == S_DONE) begin
      state_done_o = ~r_gnt_key;
      key_done_o   = r_gnt_key;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_key    <= 1'b0;
      r_rr_ptr     <= 1'b0;
      r_cnt        <= '0;
      r_work       <= '0;
      r_res        <= '0;
      r_state_data <= '0;
      r_key_data   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt_key <= w_grant_key;
            r_rr_ptr  <= ~w_grant_key;
            r_work    <= w_grant_key ? {96'd0, key_data_i} : state_data_i;
            r_cnt     <= '0;
          end
        end
        S_RUN: begin
          r_work <= {{SB{1'b0}}, r_work[127:SB]};
          r_res  <= w_res_next[127:SB];
          if (w_last) begin
            if (r_gnt_key) r_key_data   <= w_res_next[127:96];
            else           r_state_data <= w_res_next;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign state_data_o = r_state_data;
  assign key_data_o   = r_key_data;

endmodule
